// File: rtl/apb_vgachargen_bridge.sv
`default_nettype none
// ==== apb_vgachargen_bridge: APB4 completer onto the vgachargen sys-side memories ====
// ==== Rev 1.0 - initial release                                                      ====
module apb_vgachargen_bridge #(
  parameter int CH_MAP_ADDR_WIDTH  = 12,
  parameter int CH_MAP_DATA_WIDTH  = 8,
  parameter int COL_MAP_ADDR_WIDTH = 12,
  parameter int CH_T_ADDR_WIDTH    = 7,
  parameter int CH_T_DATA_WIDTH    = 128
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_arstn_i,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [31:0]                   paddr_i,
  input  logic [31:0]                   pwdata_i,
  input  logic [3:0]                    pstrb_i,
  output logic [31:0]                   prdata_o,
  output logic                          pready_o,
  output logic                          pslverr_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0]  sys_ch_map_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0]  sys_ch_map_data_o,
  output logic                          sys_ch_map_wen_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0]  sys_ch_map_data_i,
  output logic [COL_MAP_ADDR_WIDTH-1:0] sys_col_map_addr_o,
  output logic [7:0]                    sys_col_map_data_o,
  output logic                          sys_col_map_wen_o,
  input  logic [7:0]                    sys_col_map_data_i,
  output logic [CH_T_ADDR_WIDTH-1:0]    sys_ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]    sys_ch_t_rw_data_o,
  output logic                          sys_ch_t_rw_wen_o,
  input  logic [CH_T_DATA_WIDTH-1:0]    sys_ch_t_rw_data_i
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ACC_MW   = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] RD_DONE  = 3'd3;
  localparam logic [2:0] RMW_WAIT = 3'd4;
  localparam logic [2:0] RMW_WR   = 3'd5;
  localparam logic [2:0] ERR      = 3'd6;

  localparam logic [13:0] MAP_DEPTH = 14'd2400;

  logic [2:0]                   state;
  logic [1:0]                   region_q;
  logic [1:0]                   lane_q;
  logic [3:0]                   strb_q;
  logic [31:0]                  wdata_q;
  logic                         map_wen_q;
  logic [CH_MAP_ADDR_WIDTH-1:0] ch_map_addr;
  logic [CH_MAP_DATA_WIDTH-1:0] ch_map_data;
  logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr;
  logic [7:0]                   col_map_data;
  logic [CH_T_ADDR_WIDTH-1:0]   ch_t_addr;
  logic [CH_T_DATA_WIDTH-1:0]   ch_t_data;

  logic                         setup;
  logic [1:0]                   region;
  logic [13:0]                  map_idx;
  logic                         dec_err;
  logic [CH_T_DATA_WIDTH-1:0]   merged;
  logic                         unused_ok;

  assign unused_ok = ^paddr_i[1:0];

  assign setup   = (state == IDLE) && psel_i && !penable_i;
  assign region  = paddr_i[17:16];
  assign map_idx = paddr_i[15:2];
  assign dec_err = (|paddr_i[31:18]) || (region == 2'b11) ||
                   (!region[1] && (map_idx >= MAP_DEPTH)) ||
                   ((region == 2'b10) && (|paddr_i[15:11]));

  // Glyph row arrives from the memory one cycle after its address, so the merge is combinational.
  always_comb begin
    merged = sys_ch_t_rw_data_i;
    for (int k = 0; k < 4; k++) begin
      if (strb_q[k]) begin
        merged[{lane_q, 2'(k), 3'b000} +: 8] = wdata_q[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_arstn_i) begin
    if (!sys_arstn_i) begin
      state        <= IDLE;
      region_q     <= 2'b00;
      lane_q       <= 2'b00;
      strb_q       <= 4'b0000;
      wdata_q      <= 32'd0;
      map_wen_q    <= 1'b0;
      ch_map_addr  <= '0;
      ch_map_data  <= '0;
      col_map_addr <= '0;
      col_map_data <= '0;
      ch_t_addr    <= '0;
      ch_t_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            region_q  <= region;
            lane_q    <= paddr_i[3:2];
            strb_q    <= pstrb_i;
            wdata_q   <= pwdata_i;
            map_wen_q <= pstrb_i[0];
            if (dec_err) begin
              state <= ERR;
            end else begin
              case (region)
                2'b00: begin
                  ch_map_addr <= paddr_i[CH_MAP_ADDR_WIDTH+1:2];
                  if (pwrite_i) ch_map_data <= pwdata_i[CH_MAP_DATA_WIDTH-1:0];
                end
                2'b01: begin
                  col_map_addr <= paddr_i[COL_MAP_ADDR_WIDTH+1:2];
                  if (pwrite_i) col_map_data <= pwdata_i[7:0];
                end
                default: ch_t_addr <= paddr_i[CH_T_ADDR_WIDTH+3:4];
              endcase
              if (!pwrite_i)               state <= RD_WAIT;
              else if (region == 2'b10)    state <= RMW_WAIT;
              else                         state <= ACC_MW;
            end
          end
        end
        default: begin
          if (!psel_i) begin
            state <= IDLE;
          end else begin
            case (state)
              RD_WAIT:  state <= RD_DONE;
              RMW_WAIT: state <= RMW_WAIT + 3'd1;
              RMW_WR: begin
                ch_t_data <= merged;
                state     <= IDLE;
              end
              default:  state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign sys_ch_map_addr_o  = ch_map_addr;
  assign sys_ch_map_data_o  = ch_map_data;
  assign sys_col_map_addr_o = col_map_addr;
  assign sys_col_map_data_o = col_map_data;
  assign sys_ch_t_rw_addr_o = ch_t_addr;
  assign sys_ch_t_rw_data_o = (state == RMW_WR) ? merged : ch_t_data;

  // Strobes decode from state so an asynchronous reset removes them immediately.
  assign sys_ch_map_wen_o  = psel_i && (state == ACC_MW) && (region_q == 2'b00) && map_wen_q;
  assign sys_col_map_wen_o = psel_i && (state == ACC_MW) && (region_q == 2'b01) && map_wen_q;
  assign sys_ch_t_rw_wen_o = psel_i && (state == RMW_WR);

  assign pready_o  = psel_i && ((state == ACC_MW) || (state == RD_DONE) ||
                                (state == RMW_WR) || (state == ERR));
  assign pslverr_o = psel_i && (state == ERR);

  always_comb begin
    prdata_o = 32'd0;
    if (psel_i && (state == RD_DONE)) begin
      case (region_q)
        2'b00:   prdata_o = 32'(sys_ch_map_data_i);
        2'b01:   prdata_o = 32'(sys_col_map_data_i);
        default: prdata_o = sys_ch_t_rw_data_i[{lane_q, 5'b00000} +: 32];
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_vgachargen_bridge.sv
`default_nettype none
// ==== tb_apb_vgachargen_bridge: scoreboard bench with behavioural vgachargen memories ====
// ==== Rev 1.0 - initial release                                                         ====
module tb_apb_vgachargen_bridge;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]  paddr = '0, pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [31:0]  prdata;
  logic         pready, pslverr;
  logic [11:0]  ch_map_addr, col_map_addr;
  logic [7:0]   ch_map_wdata, col_map_wdata, ch_map_rdata, col_map_rdata;
  logic         ch_map_wen, col_map_wen, ch_t_wen;
  logic [6:0]   ch_t_addr;
  logic [127:0] ch_t_wdata, ch_t_rdata;

  always #5 clk = ~clk;

  apb_vgachargen_bridge dut (
    .sys_clk_i(clk), .sys_arstn_i(rst_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .sys_ch_map_addr_o(ch_map_addr), .sys_ch_map_data_o(ch_map_wdata),
    .sys_ch_map_wen_o(ch_map_wen), .sys_ch_map_data_i(ch_map_rdata),
    .sys_col_map_addr_o(col_map_addr), .sys_col_map_data_o(col_map_wdata),
    .sys_col_map_wen_o(col_map_wen), .sys_col_map_data_i(col_map_rdata),
    .sys_ch_t_rw_addr_o(ch_t_addr), .sys_ch_t_rw_data_o(ch_t_wdata),
    .sys_ch_t_rw_wen_o(ch_t_wen), .sys_ch_t_rw_data_i(ch_t_rdata)
  );

  // Synchronous-read memories, read-before-write, contents survive bridge reset.
  logic [7:0]   ch_map_mem [4096];
  logic [7:0]   col_map_mem [4096];
  logic [127:0] ch_t_mem [128];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ch_map_mem[i]  = 8'h00;
      col_map_mem[i] = 8'h00;
    end
    for (int i = 0; i < 128; i++) ch_t_mem[i] = '0;
    ch_map_rdata  = '0;
    col_map_rdata = '0;
    ch_t_rdata    = '0;
  end

  always @(posedge clk) begin
    ch_map_rdata  <= ch_map_mem[ch_map_addr];
    col_map_rdata <= col_map_mem[col_map_addr];
    ch_t_rdata    <= ch_t_mem[ch_t_addr];
    if (ch_map_wen)  ch_map_mem[ch_map_addr]  <= ch_map_wdata;
    if (col_map_wen) col_map_mem[col_map_addr] <= col_map_wdata;
    if (ch_t_wen)    ch_t_mem[ch_t_addr]      <= ch_t_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   waits = 0;
  int   n_ch_wen = 0, n_col_wen = 0, n_cht_wen = 0;

  // Monitor: pops one expectation per completed APB transfer and audits strobes.
  always @(negedge clk) begin
    if (psel && penable) begin
      if (!pready) begin
        waits++;
      end else begin
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: got prdata=%h slverr=%b with empty scoreboard", prdata, pslverr);
        end else begin
          e = exp_q.pop_front();
          if (prdata !== e.rdata || pslverr !== e.err || waits != e.waits) begin
            fails++;
            $display("FAIL apb_resp: got prdata=%h slverr=%b waits=%0d, expected prdata=%h slverr=%b waits=%0d",
                     prdata, pslverr, waits, e.rdata, e.err, e.waits);
          end
        end
        waits = 0;
      end
    end else begin
      waits = 0;
    end
    if (ch_map_wen || col_map_wen || ch_t_wen) begin
      tests++;
      if ((32'(ch_map_wen) + 32'(col_map_wen) + 32'(ch_t_wen)) != 1 || !(psel && penable && pready)) begin
        fails++;
        $display("FAIL wen_cycle: got wens=%b%b%b pready=%b, expected one wen in a response cycle",
                 ch_map_wen, col_map_wen, ch_t_wen, pready);
      end
    end
    if (ch_map_wen)  n_ch_wen++;
    if (col_map_wen) n_col_wen++;
    if (ch_t_wen)    n_cht_wen++;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Issues setup+access; leaves psel high so a following call is back-to-back.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp_rd, input bit exp_err,
                      input int exp_waits);
    exp_t e;
    bit   done = 0;
    e.rdata = exp_rd; e.err = exp_err; e.waits = exp_waits;
    exp_q.push_back(e);
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      done = pready;
      @(posedge clk); #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: addr=%h no pready within 8 cycles, expected completion", addr);
    end
    penable = 0;
  endtask

  task automatic idle();
    psel = 0; penable = 0;
    @(posedge clk); #1;
  endtask

  int c_ch, c_col, c_cht;

  initial begin
    #3;
    check("rst_prdata", 128'(prdata), 128'd0);
    check("rst_pready_slverr", 128'({pready, pslverr}), 128'd0);
    check("rst_wens", 128'({ch_map_wen, col_map_wen, ch_t_wen}), 128'd0);
    check("rst_addrs", 128'({ch_map_addr, col_map_addr, ch_t_addr}), 128'd0);
    check("rst_wdata", {ch_map_wdata, col_map_wdata, ch_t_wdata[111:0]}, 128'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 2400; i++) xfer(1, 32'h0001_0000 + 32'(i) * 4, 32'(i), 4'h1, 32'd0, 0, 0);
    for (int i = 0; i < 2400; i++) xfer(0, 32'h0001_0000 + 32'(i) * 4, 32'd0, 4'h0, {24'd0, 8'(i)}, 0, 1);
    idle();
    check("col_wen_count", 128'(n_col_wen), 128'd2400);

    c_ch = n_ch_wen;
    xfer(1, 32'h0000_0000 + 2399 * 4, 32'hFFFF_FFA5, 4'hF, 32'd0, 0, 0);
    xfer(0, 32'h0000_0000 + 2399 * 4, 32'd0, 4'h0, 32'h0000_00A5, 0, 1);
    xfer(1, 32'h0000_0000 + 2400 * 4, 32'h0000_005A, 4'hF, 32'd0, 1, 0);
    xfer(0, 32'h0000_0000 + 2399 * 4, 32'd0, 4'h0, 32'h0000_00A5, 0, 1);
    xfer(1, 32'h0000_0000 + 12 * 4, 32'h0000_0077, 4'h2, 32'd0, 0, 0);
    idle();
    check("ch_wen_count", 128'(n_ch_wen - c_ch), 128'd1);

    // Address 0x0002_0014 decodes to entry 1, lane 1.
    for (int l = 0; l < 4; l++) xfer(1, 32'h0002_0010 + 32'(l) * 4, 32'hFFFF_FFFF, 4'hF, 32'd0, 0, 1);
    idle();
    c_cht = n_cht_wen;
    xfer(1, 32'h0002_0014, 32'h1234_5678, 4'b0101, 32'd0, 0, 1);
    idle();
    check("cht_single_wen", 128'(n_cht_wen - c_cht), 128'd1);
    xfer(0, 32'h0002_0010, 32'd0, 4'h0, 32'hFFFF_FFFF, 0, 1);
    xfer(0, 32'h0002_0014, 32'd0, 4'h0, 32'hFF34_FF78, 0, 1);
    xfer(0, 32'h0002_0018, 32'd0, 4'h0, 32'hFFFF_FFFF, 0, 1);
    xfer(0, 32'h0002_001C, 32'd0, 4'h0, 32'hFFFF_FFFF, 0, 1);
    xfer(1, 32'h0002_0014, 32'hAAAA_AAAA, 4'h0, 32'd0, 0, 1);
    xfer(0, 32'h0002_0014, 32'd0, 4'h0, 32'hFF34_FF78, 0, 1);

    xfer(0, 32'h0003_0000, 32'd0, 4'h0, 32'd0, 1, 0);
    xfer(0, 32'h0004_0000, 32'd0, 4'h0, 32'd0, 1, 0);
    xfer(1, 32'h0002_0800, 32'h1, 4'hF, 32'd0, 1, 0);
    idle();

    c_cht = n_cht_wen;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0002_0010; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1;
    #2 rst_n = 0;
    #1;
    check("rst_mid_outputs", 128'({prdata, pready, pslverr, ch_map_addr, col_map_addr, ch_t_addr}), 128'd0);
    check("rst_mid_wens", 128'({ch_map_wen, col_map_wen, ch_t_wen}), 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("rst_mid_no_wen", 128'(n_cht_wen - c_cht), 128'd0);
    xfer(0, 32'h0002_0010, 32'd0, 4'h0, 32'hFFFF_FFFF, 0, 1);
    idle();

    c_ch = n_ch_wen; c_col = n_col_wen; c_cht = n_cht_wen;
    xfer(1, 32'h0001_001C, 32'h0000_003C, 4'h1, 32'd0, 0, 0);
    xfer(0, 32'h0000_0000 + 2399 * 4, 32'd0, 4'h0, 32'h0000_00A5, 0, 1);
    xfer(1, 32'h0002_002C, 32'hDEAD_BEEF, 4'hF, 32'd0, 0, 1);
    xfer(0, 32'h0001_001C, 32'd0, 4'h0, 32'h0000_003C, 0, 1);
    xfer(0, 32'h0002_002C, 32'd0, 4'h0, 32'hDEAD_BEEF, 0, 1);
    xfer(0, 32'h0002_0020, 32'd0, 4'h0, 32'h0000_0000, 0, 1);
    xfer(0, 32'h0000_0030, 32'd0, 4'h0, 32'h0000_0000, 0, 1);
    idle();
    check("b2b_wens", 128'({n_ch_wen - c_ch, n_col_wen - c_col, n_cht_wen - c_cht}),
          128'({32'd0, 32'd1, 32'd1}));
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
